// File: rtl/seq_run_det.sv
// seq_run_det: locks onto a run of RUN_LEN equal samples and counts lock events
module seq_run_det #(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8,
  parameter int HIT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             a,
  input  logic             b,
  output logic             z,
  output logic             lock_val,
  output logic [CNT_W-1:0] run_cnt,
  output logic             hit_pulse,
  output logic [HIT_W-1:0] hit_cnt,
  output logic [1:0]       state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LOCK = 2'd2, ILL = 2'd3} state_t;
  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
  state_t state;
  logic same, hit;
  logic [CNT_W-1:0] inc;
  assign same = a == lock_val;
  assign inc = run_cnt + 1'b1;
  // a lock event is either the run reaching RUN_LEN or a qualified value change while locked
  assign hit = en && ((state == RUN && same && inc == RUN_LEN_C) || (state == LOCK && !same && b));
  assign z = state == LOCK;
  assign state_dbg = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lock_val <= 1'b0;
      run_cnt <= '0;
      hit_pulse <= 1'b0;
      hit_cnt <= '0;
    end else if (clear) begin
      state <= IDLE;
      lock_val <= 1'b0;
      run_cnt <= '0;
      hit_pulse <= 1'b0;
    end else begin
      hit_pulse <= hit;
      if (hit && !(&hit_cnt)) hit_cnt <= hit_cnt + 1'b1;
      if (state == ILL) state <= IDLE;
      else if (en) begin
        case (state)
          IDLE: begin
            lock_val <= a;
            run_cnt <= 1;
            state <= RUN;
          end
          RUN: begin
            lock_val <= a;
            run_cnt <= same ? inc : CNT_W'(1);
            state <= hit ? LOCK : RUN;
          end
          LOCK: begin
            lock_val <= a;
            run_cnt <= same ? ((&run_cnt) ? run_cnt : inc) : CNT_W'(1);
            state <= (same || b) ? LOCK : RUN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_seq_run_det.sv
// tb_seq_run_det: directed checks of seq_run_det across three parameter sets
module tb_seq_run_det;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, clear = 1'b0, a = 1'b0, b = 1'b0;
  int checks = 0, errors = 0;
  logic z2, lv2, hp2, z4, lv4, hp4, zs, lvs, hps;
  logic [7:0] rc2, rc4;
  logic [2:0] rcs;
  logic [15:0] hc2, hc4;
  logic [1:0] hcs, sd2, sd4, sds;
  logic seq4 [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  int rc_exp4 [7] = '{1, 2, 1, 1, 2, 3, 4};

  always #5 clk = ~clk;

  seq_run_det #(.RUN_LEN(2)) d2 (.clk(clk), .rst(rst), .en(en), .clear(clear), .a(a), .b(b),
    .z(z2), .lock_val(lv2), .run_cnt(rc2), .hit_pulse(hp2), .hit_cnt(hc2), .state_dbg(sd2));
  seq_run_det #(.RUN_LEN(4)) d4 (.clk(clk), .rst(rst), .en(en), .clear(clear), .a(a), .b(b),
    .z(z4), .lock_val(lv4), .run_cnt(rc4), .hit_pulse(hp4), .hit_cnt(hc4), .state_dbg(sd4));
  seq_run_det #(.RUN_LEN(2), .CNT_W(3), .HIT_W(2)) ds (.clk(clk), .rst(rst), .en(en), .clear(clear),
    .a(a), .b(b), .z(zs), .lock_val(lvs), .run_cnt(rcs), .hit_pulse(hps), .hit_cnt(hcs), .state_dbg(sds));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic av, input logic bv, input logic c, input logic r);
    en = e; a = av; b = bv; clear = c; rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state and basic RUN_LEN=2 lock
    step(1, 1, 1, 0, 1);
    chk("rst_state", sd2, 0); chk("rst_z", z2, 0); chk("rst_rc", rc2, 0);
    chk("rst_lv", lv2, 0); chk("rst_hp", hp2, 0); chk("rst_hc", hc2, 0);
    step(1, 0, 0, 0, 0);
    chk("l2_state1", sd2, 1); chk("l2_rc1", rc2, 1); chk("l2_z1", z2, 0); chk("l2_hp1", hp2, 0);
    step(1, 0, 0, 0, 0);
    chk("l2_state2", sd2, 2); chk("l2_z2", z2, 1); chk("l2_hp2", hp2, 1);
    chk("l2_hc", hc2, 1); chk("l2_rc2", rc2, 2);
    step(0, 1, 0, 0, 0);
    chk("l2_hp_drop", hp2, 0); chk("l2_z_hold", z2, 1); chk("l2_lv_hold", lv2, 0);
    // qualified change keeps lock, unqualified change drops to RUN
    step(1, 1, 1, 0, 0);
    chk("b1_z", z2, 1); chk("b1_lv", lv2, 1); chk("b1_rc", rc2, 1);
    chk("b1_hp", hp2, 1); chk("b1_hc", hc2, 2);
    step(1, 0, 0, 0, 0);
    chk("b0_z", z2, 0); chk("b0_state", sd2, 1); chk("b0_rc", rc2, 1);
    chk("b0_hp", hp2, 0); chk("b0_hc", hc2, 2);
    // reset mid-run aborts without a pulse
    step(1, 0, 0, 0, 1);
    chk("mid_rst_state", sd2, 0); chk("mid_rst_hp", hp2, 0); chk("mid_rst_hc", hc2, 0);
    // en gating
    step(1, 0, 0, 0, 0);
    chk("en_s1_state", sd2, 1); chk("en_s1_rc", rc2, 1);
    step(0, 1, 1, 0, 0);
    chk("en_off1_state", sd2, 1); chk("en_off1_rc", rc2, 1); chk("en_off1_lv", lv2, 0);
    step(0, 1, 1, 0, 0);
    chk("en_off2_state", sd2, 1); chk("en_off2_rc", rc2, 1); chk("en_off2_hp", hp2, 0);
    step(1, 0, 0, 0, 0);
    chk("en_lock_z", z2, 1); chk("en_lock_hp", hp2, 1); chk("en_lock_rc", rc2, 2);
    // clear in LOCK with hit_cnt=2, then rst together with clear
    step(1, 1, 1, 0, 0);
    chk("pre_clr_hc", hc2, 2); chk("pre_clr_z", z2, 1);
    step(1, 0, 1, 1, 0);
    chk("clr_state", sd2, 0); chk("clr_z", z2, 0); chk("clr_rc", rc2, 0);
    chk("clr_lv", lv2, 0); chk("clr_hp", hp2, 0); chk("clr_hc", hc2, 2);
    step(1, 0, 0, 1, 1);
    chk("rst_clr_hc", hc2, 0); chk("rst_clr_state", sd2, 0);
    // RUN_LEN=4 with b held high while in RUN
    for (int i = 0; i < 7; i++) begin
      step(1, seq4[i], 1, 0, 0);
      chk($sformatf("r4_rc%0d", i), rc4, rc_exp4[i]);
      chk($sformatf("r4_z%0d", i), z4, i == 6);
    end
    chk("r4_hc", hc4, 1); chk("r4_hp", hp4, 1); chk("r4_state", sd4, 2);
    // narrow counters saturate
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0);
      chk($sformatf("sat_rc%0d", i), rcs, (i < 7) ? i + 1 : 7);
      if (i > 0) chk($sformatf("sat_z%0d", i), zs, 1);
    end
    chk("sat_hc1", hcs, 1);
    for (int k = 2; k <= 5; k++) begin
      step(1, k[0] ? 1'b0 : 1'b1, 1, 0, 0);
      chk($sformatf("hsat_hp%0d", k), hps, 1);
      chk($sformatf("hsat_hc%0d", k), hcs, (k < 3) ? k : 3);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
